// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch-stage sequencer.
//   Owns the program counter and issues one instruction-memory read at a time.
//   Each returned word is held in an output register until decode accepts it.
//   Redirects squash the fetch path. A HALT accepted from decode stops fetching for good.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   mem_req/mem_addr    memory read request and its address (always pc)
//   mem_done/mem_data   memory response strobe and returned instruction word
//   if_valid/if_ready   output handshake towards decode
//   if_instr/if_pc      held instruction and its address
//   if_pc_next          if_pc + PC_INC, used by decode as the link value
//   redirect_valid/_pc  restart fetch at redirect_pc (bit 0 forced to 0)
//   halt                decode saw HALT; takes effect together with a transfer
//   halted, err         sticky status: fetch stopped / request pending too long
module fetch_ctrl #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [15:0] PC_INC     = 16'h0002,
  parameter logic [7:0]  WAIT_LIMIT = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_done,
  input  logic [15:0] mem_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc,
  output logic [15:0] if_pc_next,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  input  logic        halt,
  output logic        halted,
  output logic        err
);

  typedef enum logic [1:0] {
    ST_REQ    = 2'd0,
    ST_FULL   = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic [15:0] pc_reg, pc_next;
  logic [15:0] if_instr_reg, if_instr_next;
  logic [15:0] if_pc_reg, if_pc_next_val;
  logic [7:0]  wait_cnt_reg, wait_cnt_next;
  logic        err_reg, err_next;
  logic        mem_req_reg;

  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    if_instr_next  = if_instr_reg;
    if_pc_next_val = if_pc_reg;
    wait_cnt_next  = wait_cnt_reg;
    err_next       = err_reg;

    if (state_reg != ST_HALTED) begin
      if (redirect_valid) begin
        // Redirect beats everything: a same-cycle response, transfer or
        // halt belongs to the squashed path and is dropped.
        pc_next       = redirect_pc & 16'hFFFE;
        wait_cnt_next = 8'd0;
        state_next    = ST_FLUSH;
      end else begin
        case (state_reg)
          ST_REQ: begin
            if (mem_done) begin
              if_instr_next  = mem_data;
              if_pc_next_val = pc_reg;
              pc_next        = pc_reg + PC_INC;
              state_next     = ST_FULL;
            end else begin
              // err flags once the request has been pending WAIT_LIMIT
              // cycles; the request itself keeps waiting.
              if (wait_cnt_reg == WAIT_LIMIT - 8'd1) begin
                err_next = 1'b1;
              end
              if (wait_cnt_reg != 8'hFF) begin
                wait_cnt_next = wait_cnt_reg + 8'd1;
              end
            end
          end
          ST_FULL: begin
            if (if_ready) begin
              wait_cnt_next = 8'd0;
              state_next    = halt ? ST_HALTED : ST_REQ;
            end
          end
          ST_FLUSH: begin
            state_next = ST_REQ;
          end
          default: begin
            state_next = state_reg;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= ST_REQ;
      pc_reg       <= RESET_PC;
      if_instr_reg <= 16'h0000;
      if_pc_reg    <= 16'h0000;
      wait_cnt_reg <= 8'd0;
      err_reg      <= 1'b0;
      mem_req_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      if_instr_reg <= if_instr_next;
      if_pc_reg    <= if_pc_next_val;
      wait_cnt_reg <= wait_cnt_next;
      err_reg      <= err_next;
      // Registered copy of "next state is REQ" so the request line never
      // depends combinationally on inputs and is low while in reset.
      mem_req_reg  <= (state_next == ST_REQ);
    end
  end

  assign mem_req    = mem_req_reg;
  assign mem_addr   = pc_reg;
  assign if_valid   = (state_reg == ST_FULL);
  assign if_instr   = if_instr_reg;
  assign if_pc      = if_pc_reg;
  assign if_pc_next = if_pc_reg + PC_INC;
  assign halted     = (state_reg == ST_HALTED);
  assign err        = err_reg;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: randomized and directed stimulus for fetch_ctrl, checked every
// cycle against a transaction-level model of the fetch stage, plus literal
// expectations for the directed scenarios.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_done = 1'b0;
  logic [15:0] mem_data = 16'h0000;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic [15:0] if_pc_next;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        halt = 1'b0;
  logic        halted;
  logic        err;

  int n_pass  = 0;
  int n_total = 0;

  fetch_ctrl dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_done(mem_done), .mem_data(mem_data),
    .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc), .if_pc_next(if_pc_next),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt(halt), .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // holding: a word is waiting for decode; bubble: one dead cycle after a
  // redirect; stopped: halt taken; pending: cycles the current request waited.
  logic [15:0] m_pc, m_word, m_word_pc;
  bit          m_holding, m_bubble, m_stopped, m_err;
  int          m_pending;

  function automatic void model_reset();
    m_pc      = 16'h0000;
    m_word    = 16'h0000;
    m_word_pc = 16'h0000;
    m_holding = 1'b0;
    m_bubble  = 1'b0;
    m_stopped = 1'b0;
    m_err     = 1'b0;
    m_pending = 0;
  endfunction

  function automatic void model_step(bit done, bit ready, bit rv, logic [15:0] rpc,
                                     bit h, logic [15:0] data);
    if (m_stopped) return;
    if (rv) begin
      m_pc      = {rpc[15:1], 1'b0};
      m_holding = 1'b0;
      m_bubble  = 1'b1;
      m_pending = 0;
    end else if (m_bubble) begin
      m_bubble = 1'b0;
    end else if (m_holding) begin
      if (ready) begin
        m_holding = 1'b0;
        m_pending = 0;
        if (h) m_stopped = 1'b1;
      end
    end else if (done) begin
      m_word    = data;
      m_word_pc = m_pc;
      m_pc      = 16'(m_pc + 16'd2);
      m_holding = 1'b1;
    end else begin
      // 255 fruitless waiting cycles raise err
      m_pending++;
      if (m_pending == 255) m_err = 1'b1;
    end
  endfunction

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic compare_all();
    bit exp_req;
    exp_req = !m_holding && !m_bubble && !m_stopped;
    chk("mem_req",  16'(mem_req),  16'(exp_req));
    chk("mem_addr", mem_addr,      m_pc);
    chk("if_valid", 16'(if_valid), 16'(m_holding));
    chk("halted",   16'(halted),   16'(m_stopped));
    chk("err",      16'(err),      16'(m_err));
    if (m_holding) begin
      chk("if_instr",   if_instr,   m_word);
      chk("if_pc",      if_pc,      m_word_pc);
      chk("if_pc_next", if_pc_next, 16'(m_word_pc + 16'd2));
    end
  endtask

  // One clock: compare at the falling edge, then drive this cycle's inputs.
  // The memory answers only while a request is up, unless spur is set.
  task automatic cycle(bit done_en, bit ready, bit rv, logic [15:0] rpc, bit h,
                       logic [15:0] data, bit spur);
    @(negedge clk);
    compare_all();
    mem_done       = done_en && (mem_req || spur);
    mem_data       = data;
    if_ready       = ready;
    redirect_valid = rv;
    redirect_pc    = rpc;
    halt           = h;
    model_step(mem_done, ready, rv, rpc, h, data);
  endtask

  task automatic rand_cycle(bit halt_en);
    cycle($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 50,
          $urandom_range(0, 99) < 5, 16'($urandom),
          halt_en && ($urandom_range(0, 99) < 10), 16'($urandom),
          $urandom_range(0, 99) < 5);
  endtask

  // Assert reset between clock edges, check the asynchronous effect, hold it
  // across one rising edge, then release on a falling edge.
  task automatic async_reset();
    #2;
    rst            = 1'b0;
    mem_done       = 1'b0;
    if_ready       = 1'b0;
    redirect_valid = 1'b0;
    halt           = 1'b0;
    #1;
    chk("rst_async_mem_req",  16'(mem_req),  16'h0);
    chk("rst_async_if_valid", 16'(if_valid), 16'h0);
    chk("rst_async_err",      16'(err),      16'h0);
    chk("rst_async_halted",   16'(halted),   16'h0);
    model_reset();
    @(negedge clk);
    chk("rst_mem_req",  16'(mem_req), 16'h0);
    chk("rst_mem_addr", mem_addr,     16'h0000);
    chk("rst_if_instr", if_instr,     16'h0000);
    chk("rst_if_pc",    if_pc,        16'h0000);
    rst = 1'b1;
    model_step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
  endtask

  initial begin
    logic [15:0] saved_pc;

    async_reset();

    // 1: memory answers in the request cycle -> one word every 2 cycles
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 16'($urandom), 1'b0);
      chk("t1_valid",   16'(if_valid), 16'(i % 2));
      chk("t1_mem_req", 16'(mem_req),  16'((i + 1) % 2));
      if (i % 2 == 1) chk("t1_if_pc", if_pc, 16'((i / 2) * 2));
    end

    // 2: decode stalls for 5 cycles while holding A5A5
    cycle(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'hA5A5, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'($urandom), 1'b0);
      chk("t2_instr",   if_instr,     16'hA5A5);
      chk("t2_pc",      if_pc,        16'h0006);
      chk("t2_mem_req", 16'(mem_req), 16'h0);
    end
    cycle(1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    saved_pc = if_pc;
    cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    chk("t2_next_addr", mem_addr, 16'(saved_pc + 16'd2));

    // 3: request pending 3 cycles, redirect collides with the response
    cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 16'h0101, 1'b0, 16'hDEAD, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    chk("t3_flush_req",   16'(mem_req),  16'h0);
    chk("t3_flush_valid", 16'(if_valid), 16'h0);
    cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    chk("t3_addr", mem_addr,     16'h0100);
    chk("t3_req",  16'(mem_req), 16'h1);

    // 4: fetch at the top of the address space wraps to 0
    cycle(1'b0, 1'b0, 1'b1, 16'hFFFE, 1'b0, 16'h0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h1111, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    chk("t4_if_pc",      if_pc,      16'hFFFE);
    chk("t4_if_pc_next", if_pc_next, 16'h0000);
    cycle(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    chk("t4_wrap_addr", mem_addr, 16'h0000);
    cycle(1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);

    // 6: response withheld 255 cycles -> err exactly at the limit
    for (int i = 0; i < 255; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
      if (i == 0 || i == 254) chk("t6_err_low", 16'(err), 16'h0);
    end
    cycle(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h1234, 1'b0);
    chk("t6_err_set", 16'(err), 16'h1);
    cycle(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    chk("t6_instr",     if_instr, 16'h1234);
    chk("t6_err_stays", 16'(err), 16'h1);

    // random traffic without halt, then a reset while requesting
    for (int i = 0; i < 1500; i++) rand_cycle(1'b0);
    cycle(1'b0, 1'b0, 1'b1, 16'($urandom), 1'b0, 16'h0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    chk("pre_rst_req", 16'(mem_req), 16'h1);
    async_reset();

    // 5b: redirect and halt together -> redirect wins
    cycle(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h7777, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 16'h0040, 1'b1, 16'h0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    chk("t5b_halted", 16'(halted), 16'h0);
    cycle(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h4444, 1'b0);
    chk("t5b_addr", mem_addr, 16'h0040);
    cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    chk("t5b_if_pc", if_pc, 16'h0040);
    cycle(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);

    // random traffic including halts; reset some cycles after each halt
    for (int i = 0; i < 2000; i++) begin
      if (m_stopped && $urandom_range(0, 3) == 0) async_reset();
      else rand_cycle(1'b1);
    end
    async_reset();

    // 5a: halt held off by if_ready=0, then taken with the transfer
    cycle(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h5A5A, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h0, 1'b0);
    chk("t5a_hold_valid",  16'(if_valid), 16'h1);
    chk("t5a_hold_halted", 16'(halted),   16'h0);
    cycle(1'b0, 1'b1, 1'b0, 16'h0, 1'b1, 16'h0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b1, $urandom_range(0, 1) == 1, 16'($urandom), 1'b1,
            16'($urandom), 1'b1);
      chk("t5a_halted",  16'(halted),   16'h1);
      chk("t5a_mem_req", 16'(mem_req),  16'h0);
      chk("t5a_valid",   16'(if_valid), 16'h0);
    end

    @(negedge clk);
    compare_all();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
